multicycle_controller: RTL and testbench

- Control FSM for the multi-cycle RV32I datapath. It sequences one shared ALU, one unified instruction/data memory port, the IR/OldPC/ALUOut/Data registers and the register file.
- Decodes op/funct3/funct7b5 from the IR into per-state datapath enables and mux selects.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Sits beside the datapath as the sequential counterpart of the single-cycle Controller.

---
 rtl/multicycle_controller.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multi-cycle RV32I datapath.
// It sequences the shared ALU, the unified instruction/data memory port,
// the IR/OldPC/ALUOut/Data registers and the register file.
// Supported instructions are lw, sw, R-type, I-type ALU, beq and jal.
//
// Optional feature macro: MC_MEM_WAIT_EN. When it is defined, the input
// mem_ready is added and FETCH/MEMREAD/MEMWRITE wait for it.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   op, funct3, funct7b5    instruction fields from the IR
//   Zero                    ALU zero flag, sampled in BEQ
//   mem_ready               memory handshake (MC_MEM_WAIT_EN only)
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl datapath selects
//   illegal_op              pulse in DECODE for an unsupported opcode
//   instr_done              pulse on the last cycle of each instruction
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
`ifdef MC_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_op,
  output logic       instr_done
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Per-state (Moore) controls, registered together with the state.
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
  } ctl_t;

  state_t state, state_nxt;
  ctl_t   ctl;
  logic   mem_ok;
  logic   op_ok;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  function automatic ctl_t moore(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'b10;
        c.result_src = 2'b10; c.pc_update = 1'b1;
      end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      EXECI: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10;
      end
      ALUWB:    c.reg_write = 1'b1;
      BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      JAL: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                 (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = mem_ok ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECR;
          OP_I:         state_nxt = EXECI;
          OP_BEQ:       state_nxt = BEQ;
          OP_JAL:       state_nxt = JAL;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR:   state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nxt = mem_ok ? MEMWB : MEMREAD;
      MEMWRITE: state_nxt = mem_ok ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL: state_nxt = ALUWB;
      default:  state_nxt = FETCH;  // MEMWB, ALUWB, BEQ and unused codes
    endcase
  end

  // State and Moore controls share one register so the controls always
  // match the state they describe, including straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      ctl   <= moore(FETCH);
    end else begin
      state <= state_nxt;
      ctl   <= moore(state_nxt);
    end
  end

  // Only the FETCH update waits on memory; the JAL PC update does not.
  assign PCWrite   = (ctl.pc_update & ((state != FETCH) | mem_ok)) |
                     (ctl.branch & Zero);
  assign IRWrite   = ctl.ir_write & mem_ok;
  assign AdrSrc    = ctl.adr_src;
  assign MemWrite  = ctl.mem_write;
  assign RegWrite  = ctl.reg_write;
  assign ResultSrc = ctl.result_src;
  assign ALUSrcA   = ctl.alu_src_a;
  assign ALUSrcB   = ctl.alu_src_b;

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_SW:   ImmSrc = 3'b001;
      OP_BEQ:  ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      default: ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (ctl.alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          // op[5] separates R-type from I-type: addi never subtracts.
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  assign illegal_op = (state == DECODE) & ~op_ok;
  assign instr_done = (state == MEMWB) | (state == ALUWB) | (state == BEQ) |
                      ((state == MEMWRITE) & mem_ok) | illegal_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller. Each
// instruction is modelled as its list of states; expected outputs are
// derived per state from the control table.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic       illegal_op, instr_done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                 S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7,
                 S_ALUWB = 8, S_BEQ = 9, S_JAL = 10;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero),
`ifdef MC_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal_op(illegal_op), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] dut_outs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ImmSrc, ALUControl, illegal_op, instr_done};
  endfunction

  function automatic bit legal(logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  // Expected outputs straight from the per-state control table.
  function automatic logic [18:0] exp_outs(int st, logic [6:0] o, logic [2:0] f3,
                                           logic f7, logic z, logic rdy);
    logic pcw, adr, mw, irw, rw, ill, done;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm, alu;
    pcw = (st == S_FETCH && rdy) || st == S_JAL || (st == S_BEQ && z);
    adr = (st == S_MEMREAD || st == S_MEMWRITE);
    mw  = (st == S_MEMWRITE);
    irw = (st == S_FETCH && rdy);
    rw  = (st == S_MEMWB || st == S_ALUWB);
    rs  = (st == S_FETCH) ? 2'b10 : (st == S_MEMWB) ? 2'b01 : 2'b00;
    sa  = (st == S_DECODE || st == S_JAL) ? 2'b01 :
          (st == S_MEMADR || st == S_EXECR || st == S_EXECI || st == S_BEQ) ? 2'b10 : 2'b00;
    sb  = (st == S_FETCH || st == S_JAL) ? 2'b10 :
          (st == S_DECODE || st == S_MEMADR || st == S_EXECI) ? 2'b01 : 2'b00;
    case (o)
      7'b0100011: imm = 3'b001;
      7'b1100011: imm = 3'b010;
      7'b1101111: imm = 3'b011;
      default:    imm = 3'b000;
    endcase
    alu = 3'b000;
    if (st == S_BEQ) alu = 3'b001;
    else if (st == S_EXECR || st == S_EXECI) begin
      case (f3)
        3'b000:  alu = (st == S_EXECR && f7) ? 3'b001 : 3'b000;
        3'b010:  alu = 3'b101;
        3'b110:  alu = 3'b011;
        3'b111:  alu = 3'b010;
        default: alu = 3'b000;
      endcase
    end
    ill  = (st == S_DECODE) && !legal(o);
    done = st == S_MEMWB || st == S_ALUWB || st == S_BEQ ||
           (st == S_MEMWRITE && rdy) || ill;
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill, done};
  endfunction

  // Runs one instruction; starts and ends just after a falling edge.
  // abort_rd: assert reset while in MEMREAD. stall_fetch: forced
  // not-ready cycles at the start of FETCH (wait-enabled builds only).
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input bit abort_rd, input int stall_fetch);
    int seq[$];
    int idx = 0, cyc = 0, ndone = 0, stalls = stall_fetch;
    logic rdy;
    case (o)
      7'b0000011: seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
      7'b0100011: seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
      7'b0110011: seq = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
      7'b0010011: seq = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB};
      7'b1100011: seq = '{S_FETCH, S_DECODE, S_BEQ};
      7'b1101111: seq = '{S_FETCH, S_DECODE, S_JAL, S_ALUWB};
      default:    seq = '{S_FETCH, S_DECODE};
    endcase
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    while (idx < seq.size() && cyc < 60) begin
      int st = seq[idx];
      bit waitable = (st == S_FETCH || st == S_MEMREAD || st == S_MEMWRITE);
`ifdef MC_MEM_WAIT_EN
      if (stalls > 0 && st == S_FETCH) begin rdy = 1'b0; stalls--; end
      else rdy = ($urandom_range(0, 3) != 0);
`else
      rdy = 1'b1;
`endif
      mem_ready = rdy;
      #1;
      chk("state", 32'(dut.state), st);
      chk("outs", 32'(dut_outs()), 32'(exp_outs(st, o, f3, f7, z, rdy)));
      if (instr_done) ndone++;
      if (abort_rd && st == S_MEMREAD) begin
        mem_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(dut.state), S_FETCH);
        chk("rst_irw", 32'(IRWrite), 1);
        chk("rst_pcw", 32'(PCWrite), 1);
        chk("rst_rw", 32'(RegWrite), 0);
        chk("rst_mw", 32'(MemWrite), 0);
        chk("rst_done", 32'(instr_done), 0);
        @(negedge clk);
        #1;
        chk("rst_hold", 32'(dut.state), S_FETCH);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (!(waitable && !rdy)) idx++;
      cyc++;
      @(negedge clk);
    end
    chk("finished", 32'(idx), 32'(seq.size()));
    chk("done_cnt", 32'(ndone), 1);
  endtask

  initial begin
    logic [6:0] ops[6];
    logic [6:0] o;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    rst_n = 1'b0; op = 7'b0000011; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("in_reset", 32'(dut_outs()), 32'(exp_outs(S_FETCH, op, funct3, funct7b5, Zero, 1'b1)));
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0);  // lw
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b1, 0, 0);  // sw
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);  // sub
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);  // addi, same funct bits
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);  // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);  // beq not taken
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 3);  // illegal, stalled fetch
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);  // jal
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1, 0);  // lw aborted by reset
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b1, 0, 0);  // and after reset

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do o = 7'($urandom); while (legal(o));
      end else o = ops[$urandom_range(0, 5)];
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), 0,
                ($urandom_range(0, 9) == 0) ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
